// File: rtl/memory_requester_pkg.sv
// Shared widths and FSM state encoding for the data-memory requester.
package memory_requester_pkg;

  localparam int unsigned DATA_WIDTH  = 8;
  localparam int unsigned BURST_WIDTH = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    RESP  = 2'd2,
    WRITE = 2'd3
  } memReqState_t;

endpackage

// File: rtl/memory_requester.sv
// Initiator side of the data-memory port: accepts load/store requests, issues
// single-word stores and burst loads, and returns read beats over valid/ready.
module memory_requester #(
  parameter int unsigned DATA_WIDTH  = memory_requester_pkg::DATA_WIDTH,
  parameter int unsigned BURST_WIDTH = memory_requester_pkg::BURST_WIDTH
) (
  input  logic                   _CLK,
  input  logic                   _RESET,
  input  logic                   _reqValid,
  input  logic                   _reqWrite,
  input  logic [DATA_WIDTH-1:0]  _reqAddress,
  input  logic [DATA_WIDTH-1:0]  _reqData,
  input  logic [BURST_WIDTH-1:0] _reqCount,
  output logic                   reqReady,
  output logic                   respValid,
  output logic [DATA_WIDTH-1:0]  respData,
  output logic                   respLast,
  input  logic                   _respReady,
  output logic                   writeDone,
  output logic                   memRead,
  output logic                   memWrite,
  output logic [DATA_WIDTH-1:0]  memAddress,
  output logic [DATA_WIDTH-1:0]  memValueOut,
  input  logic [DATA_WIDTH-1:0]  _memValueIn
);

  import memory_requester_pkg::*;

  memReqState_t            state_q, state_d;
  logic [DATA_WIDTH-1:0]   addr_q, addr_d;
  logic [BURST_WIDTH-1:0]  remaining_q, remaining_d;
  logic [DATA_WIDTH-1:0]   resp_data_q, resp_data_d;
  logic                    resp_last_q, resp_last_d;
  logic                    resp_valid_q, resp_valid_d;
  logic                    write_done_q, write_done_d;
  logic                    mem_read_q, mem_read_d;
  logic                    mem_write_q, mem_write_d;
  logic [DATA_WIDTH-1:0]   mem_address_q, mem_address_d;
  logic [DATA_WIDTH-1:0]   mem_value_q, mem_value_d;

  // Next-state and next-output logic; memory strobes are one-cycle by default.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    remaining_d   = remaining_q;
    resp_data_d   = resp_data_q;
    resp_last_d   = resp_last_q;
    resp_valid_d  = resp_valid_q;
    write_done_d  = 1'b0;
    mem_read_d    = 1'b0;
    mem_write_d   = 1'b0;
    mem_address_d = mem_address_q;
    mem_value_d   = mem_value_q;

    case (state_q)
      IDLE: begin
        if (_reqValid) begin
          addr_d        = _reqAddress;
          remaining_d   = _reqCount;
          mem_address_d = _reqAddress;
          if (_reqWrite) begin
            mem_write_d = 1'b1;
            mem_value_d = _reqData;
            state_d     = WRITE;
          end else begin
            mem_read_d = 1'b1;
            state_d    = READ;
          end
        end
      end

      READ: begin
        resp_data_d  = _memValueIn;
        resp_last_d  = (remaining_q == '0);
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end

      RESP: begin
        if (_respReady) begin
          resp_valid_d = 1'b0;
          resp_last_d  = 1'b0;
          if (remaining_q == '0) begin
            state_d = IDLE;
          end else begin
            // Address wraps modulo the memory size.
            addr_d        = DATA_WIDTH'(addr_q + DATA_WIDTH'(1));
            remaining_d   = BURST_WIDTH'(remaining_q - BURST_WIDTH'(1));
            mem_address_d = DATA_WIDTH'(addr_q + DATA_WIDTH'(1));
            mem_read_d    = 1'b1;
            state_d       = READ;
          end
        end
      end

      WRITE: begin
        write_done_d = 1'b1;
        state_d      = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge _CLK) begin
    if (_RESET) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      remaining_q   <= '0;
      resp_data_q   <= '0;
      resp_last_q   <= 1'b0;
      resp_valid_q  <= 1'b0;
      write_done_q  <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_value_q   <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      remaining_q   <= remaining_d;
      resp_data_q   <= resp_data_d;
      resp_last_q   <= resp_last_d;
      resp_valid_q  <= resp_valid_d;
      write_done_q  <= write_done_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_value_q   <= mem_value_d;
    end
  end

  // Ready is held low for the whole time reset is asserted, not just after the edge.
  assign reqReady    = (state_q == IDLE) && !_RESET;
  assign respValid   = resp_valid_q;
  assign respData    = resp_data_q;
  assign respLast    = resp_last_q;
  assign writeDone   = write_done_q;
  assign memRead     = mem_read_q;
  assign memWrite    = mem_write_q;
  assign memAddress  = mem_address_q;
  assign memValueOut = mem_value_q;

endmodule

// File: tb/tb_memory_requester.sv
// Scoreboard bench for memory_requester against a combinational-read memory model.
module tb_memory_requester;

  localparam int unsigned DW = 8;
  localparam int unsigned BW = 3;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_write;
  logic [DW-1:0] req_addr, req_data;
  logic [BW-1:0] req_count;
  logic          req_ready;
  logic          resp_valid, resp_last, resp_ready;
  logic [DW-1:0] resp_data;
  logic          write_done, mem_read, mem_write;
  logic [DW-1:0] mem_address, mem_value_out, mem_value_in;

  logic [DW-1:0] mem [256];
  beat_t         exp_q[$];
  logic [DW-1:0] exp_addr_q[$];
  int            n_checks = 0;
  int            n_pass = 0;
  int            excl_err = 0;

  memory_requester dut (
    ._CLK(clk), ._RESET(rst),
    ._reqValid(req_valid), ._reqWrite(req_write), ._reqAddress(req_addr),
    ._reqData(req_data), ._reqCount(req_count), .reqReady(req_ready),
    .respValid(resp_valid), .respData(resp_data), .respLast(resp_last),
    ._respReady(resp_ready), .writeDone(write_done),
    .memRead(mem_read), .memWrite(mem_write), .memAddress(mem_address),
    .memValueOut(mem_value_out), ._memValueIn(mem_value_in)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_write) mem[mem_address] <= mem_value_out;
  assign mem_value_in = mem[mem_address];

  always @(negedge clk)
    if ((mem_read && mem_write) || (write_done && resp_valid)) excl_err++;

  task automatic do_store(input logic [DW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_data = d; req_count = '0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic start_read(input logic [DW-1:0] a, input logic [BW-1:0] cnt);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_count = cnt; req_data = 8'hEE;
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_data = '0;
    req_count = '0; resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b0) $display("FAIL reset_ready: got %b expected 0", req_ready);
    else n_pass++;
    n_checks++;
    if ({resp_valid, resp_data, resp_last, write_done, mem_read, mem_write, mem_address, mem_value_out} !== '0)
      $display("FAIL reset_outputs: got valid=%b data=%h last=%b wd=%b rd=%b wr=%b addr=%h val=%h expected all 0",
               resp_valid, resp_data, resp_last, write_done, mem_read, mem_write, mem_address, mem_value_out);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL idle_ready: got %b expected 1", req_ready);
    else n_pass++;
  endtask

  task automatic test_store;
    beat_t e;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h10; req_data = 8'hA5;
    @(negedge clk);
    req_valid = 1'b0;
    n_checks++;
    if (mem_write !== 1'b1 || mem_address !== 8'h10 || mem_value_out !== 8'hA5 || write_done !== 1'b0)
      $display("FAIL store_issue: got wr=%b addr=%h val=%h wd=%b expected 1/10/a5/0",
               mem_write, mem_address, mem_value_out, write_done);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (mem_write !== 1'b0 || write_done !== 1'b1)
      $display("FAIL store_done: got wr=%b wd=%b expected 0/1", mem_write, write_done);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (mem_write !== 1'b0 || write_done !== 1'b0)
      $display("FAIL store_pulse: got wr=%b wd=%b expected 0/0", mem_write, write_done);
    else n_pass++;
    n_checks++;
    if (mem[8'h10] !== 8'hA5) $display("FAIL store_mem: got %h expected a5", mem[8'h10]);
    else n_pass++;

    exp_q.push_back(beat_t'({8'hA5, 1'b1}));
    start_read(8'h10, 3'd0);
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (resp_valid && resp_ready) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({resp_data, resp_last} !== e)
          $display("FAIL store_readback: got data=%h last=%b expected data=%h last=%b",
                   resp_data, resp_last, e.data, e.last);
        else n_pass++;
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      $display("FAIL store_readback_timeout: %0d beats missing expected 0", exp_q.size());
      exp_q.delete();
    end else n_pass++;
  endtask

  task automatic test_burst;
    beat_t e;
    int    last_c = -1;
    do_store(8'h20, 8'h01); do_store(8'h21, 8'h02);
    do_store(8'h22, 8'h03); do_store(8'h23, 8'h04);
    exp_q.push_back(beat_t'({8'h01, 1'b0})); exp_q.push_back(beat_t'({8'h02, 1'b0}));
    exp_q.push_back(beat_t'({8'h03, 1'b0})); exp_q.push_back(beat_t'({8'h04, 1'b1}));
    resp_ready = 1'b1;
    start_read(8'h20, 3'd3);
    for (int c = 0; c < 60 && exp_q.size() != 0; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (resp_valid && resp_ready) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({resp_data, resp_last} !== e)
          $display("FAIL burst_beat: got data=%h last=%b expected data=%h last=%b",
                   resp_data, resp_last, e.data, e.last);
        else n_pass++;
        if (last_c >= 0) begin
          n_checks++;
          if (c - last_c != 2) $display("FAIL burst_gap: got %0d cycles expected 2", c - last_c);
          else n_pass++;
        end
        last_c = c;
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      $display("FAIL burst_timeout: %0d beats missing expected 0", exp_q.size());
      exp_q.delete();
    end else n_pass++;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0)
      $display("FAIL burst_idle: got ready=%b valid=%b expected 1/0", req_ready, resp_valid);
    else n_pass++;
  endtask

  task automatic test_backpressure;
    beat_t e;
    int    beat_idx = 0;
    int    stall_cnt = 0;
    exp_q.push_back(beat_t'({8'h01, 1'b0})); exp_q.push_back(beat_t'({8'h02, 1'b0}));
    exp_q.push_back(beat_t'({8'h03, 1'b0})); exp_q.push_back(beat_t'({8'h04, 1'b1}));
    start_read(8'h20, 3'd3);
    for (int c = 0; c < 80 && exp_q.size() != 0; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (resp_valid && beat_idx == 1 && stall_cnt < 5) begin
        n_checks++;
        if (resp_data !== 8'h02 || resp_last !== 1'b0 || mem_read !== 1'b0)
          $display("FAIL stall_hold: got data=%h last=%b rd=%b expected 02/0/0",
                   resp_data, resp_last, mem_read);
        else n_pass++;
        stall_cnt++;
        resp_ready = 1'b0;
      end else begin
        resp_ready = 1'b1;
      end
      if (resp_valid && resp_ready) begin
        e = exp_q.pop_front();
        beat_idx++;
        n_checks++;
        if ({resp_data, resp_last} !== e)
          $display("FAIL stall_beat: got data=%h last=%b expected data=%h last=%b",
                   resp_data, resp_last, e.data, e.last);
        else n_pass++;
      end
    end
    resp_ready = 1'b1;
    n_checks++;
    if (exp_q.size() != 0 || stall_cnt != 5) begin
      $display("FAIL stall_done: got missing=%0d stalls=%0d expected 0/5", exp_q.size(), stall_cnt);
      exp_q.delete();
    end else n_pass++;
  endtask

  task automatic test_wrap;
    beat_t         e;
    logic [DW-1:0] ea;
    do_store(8'hFE, 8'h11); do_store(8'hFF, 8'h22); do_store(8'h00, 8'h33);
    exp_q.push_back(beat_t'({8'h11, 1'b0})); exp_q.push_back(beat_t'({8'h22, 1'b0}));
    exp_q.push_back(beat_t'({8'h33, 1'b1}));
    exp_addr_q.push_back(8'hFE); exp_addr_q.push_back(8'hFF); exp_addr_q.push_back(8'h00);
    start_read(8'hFE, 3'd2);
    for (int c = 0; c < 60 && exp_q.size() != 0; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (mem_read && exp_addr_q.size() != 0) begin
        ea = exp_addr_q.pop_front();
        n_checks++;
        if (mem_address !== ea) $display("FAIL wrap_addr: got %h expected %h", mem_address, ea);
        else n_pass++;
      end
      if (resp_valid && resp_ready) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({resp_data, resp_last} !== e)
          $display("FAIL wrap_beat: got data=%h last=%b expected data=%h last=%b",
                   resp_data, resp_last, e.data, e.last);
        else n_pass++;
      end
    end
    n_checks++;
    if (exp_q.size() != 0 || exp_addr_q.size() != 0) begin
      $display("FAIL wrap_timeout: got missing beats=%0d addrs=%0d expected 0/0",
               exp_q.size(), exp_addr_q.size());
      exp_q.delete(); exp_addr_q.delete();
    end else n_pass++;
  endtask

  task automatic test_busy;
    beat_t e;
    int    viol = 0;
    int    held = 0;
    exp_q.push_back(beat_t'({8'h01, 1'b0})); exp_q.push_back(beat_t'({8'h02, 1'b0}));
    exp_q.push_back(beat_t'({8'h03, 1'b0})); exp_q.push_back(beat_t'({8'h04, 1'b1}));
    start_read(8'h20, 3'd3);
    for (int c = 0; c < 60 && exp_q.size() != 0; c++) begin
      @(negedge clk);
      if (c == 0) req_valid = 1'b0;
      if (resp_valid && !req_valid) begin
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h40; req_data = 8'h5A;
      end
      if (req_valid) begin
        held++;
        if (req_ready || mem_write) viol++;
      end
      if (resp_valid && resp_ready) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({resp_data, resp_last} !== e)
          $display("FAIL busy_beat: got data=%h last=%b expected data=%h last=%b",
                   resp_data, resp_last, e.data, e.last);
        else n_pass++;
      end
    end
    n_checks++;
    if (viol != 0 || held == 0 || exp_q.size() != 0) begin
      $display("FAIL busy_hold: got violations=%0d held=%0d missing=%0d expected 0/>0/0",
               viol, held, exp_q.size());
      exp_q.delete();
    end else n_pass++;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL busy_ready: got %b expected 1", req_ready);
    else n_pass++;
    @(negedge clk);
    req_valid = 1'b0;
    n_checks++;
    if (mem_write !== 1'b1 || mem_address !== 8'h40 || mem_value_out !== 8'h5A)
      $display("FAIL busy_write: got wr=%b addr=%h val=%h expected 1/40/5a",
               mem_write, mem_address, mem_value_out);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (write_done !== 1'b1 || mem[8'h40] !== 8'h5A)
      $display("FAIL busy_done: got wd=%b mem=%h expected 1/5a", write_done, mem[8'h40]);
    else n_pass++;
  endtask

  task automatic test_reset_resp;
    int found = 0;
    int stray = 0;
    start_read(8'h20, 3'd3);
    for (int c = 0; c < 10 && found == 0; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (resp_valid) begin
        found = 1;
        resp_ready = 1'b0;
        rst = 1'b1;
      end
    end
    @(negedge clk);
    n_checks++;
    if (found == 0 || req_ready !== 1'b0 ||
        {resp_valid, resp_data, resp_last, write_done, mem_read, mem_write, mem_address, mem_value_out} !== '0)
      $display("FAIL reset_resp: got found=%0d ready=%b valid=%b data=%h last=%b rd=%b wr=%b addr=%h val=%h expected all 0 after beat",
               found, req_ready, resp_valid, resp_data, resp_last, mem_read, mem_write, mem_address, mem_value_out);
    else n_pass++;
    rst = 1'b0;
    resp_ready = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (resp_valid || mem_read) stray++;
    end
    n_checks++;
    if (stray != 0 || req_ready !== 1'b1)
      $display("FAIL reset_resp_after: got stray=%0d ready=%b expected 0/1", stray, req_ready);
    else n_pass++;
  endtask

  task automatic test_reset_write;
    int stray = 0;
    do_store(8'h50, 8'h00);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h50; req_data = 8'h77;
    @(negedge clk);
    req_valid = 1'b0;
    n_checks++;
    if (mem_write !== 1'b1) $display("FAIL reset_write_issue: got wr=%b expected 1", mem_write);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    if (write_done) stray++;
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (write_done) stray++;
    end
    n_checks++;
    if (stray != 0 || mem[8'h50] !== 8'h77)
      $display("FAIL reset_write: got wd pulses=%0d mem=%h expected 0/77", stray, mem[8'h50]);
    else n_pass++;
  endtask

  task automatic test_exclusive;
    n_checks++;
    if (excl_err != 0) $display("FAIL exclusive: got %0d overlap cycles expected 0", excl_err);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_store();
    test_burst();
    test_backpressure();
    test_wrap();
    test_busy();
    test_reset_resp();
    test_reset_write();
    test_exclusive();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
